vga_timing_gen: RTL and testbench

- Fully parametrised VGA/raster timing generator that replaces the fixed 640-column single-FSM display controller.
- Produces registered HSync, VSync, display-enable and active-area pixel coordinates from one pixel clock.
- Adds the following: independent horizontal and vertical porch/sync parameters, programmable sync polarity, a pixel-enable (clock-divide) input, and line/frame start strobes.
- Sits between the pixel clock domain and the framebuffer/pattern logic, which uses oCol/oRow to fetch pixels.

---
 rtl/vga_timing_gen.sv | 239 +++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: registered syncs, display enable, pixel coordinates and strobes.
// Optional macro VGA_TIMING_PREFETCH_EN adds oPreCol/oPreRow/oPreDisplay (next-pixel lookahead).
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int XWidth   = 10,
  parameter int YWidth   = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iEnable,
  output logic [XWidth-1:0] oCol,
  output logic [YWidth-1:0] oRow,
  output logic              oHSync,
  output logic              oVSync,
  output logic              oDisplay,
  output logic              oLineStart,
  output logic              oFrameStart
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic [XWidth-1:0] oPreCol,
  output logic [YWidth-1:0] oPreRow,
  output logic              oPreDisplay
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 4095");
  end
  if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_active
    $error("vga_timing_gen: H_ACTIVE and V_ACTIVE must be at least 1");
  end

  typedef enum logic [1:0] {ST_SYNC, ST_BACK, ST_ACTIVE, ST_FRONT} state_e;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    state_e      hs;
    state_e      vs;
  } pos_t;

  // Last counter value of each state; zero-length states are never entered, so their value is unused.
  localparam logic [11:0] H_LAST_SYNC = 12'(H_SYNC - 1);
  localparam logic [11:0] H_LAST_BACK = 12'(H_SYNC + H_BACK - 1);
  localparam logic [11:0] H_LAST_ACT  = 12'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [11:0] H_LAST_TOT  = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_OFF       = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] V_LAST_SYNC = 12'(V_SYNC - 1);
  localparam logic [11:0] V_LAST_BACK = 12'(V_SYNC + V_BACK - 1);
  localparam logic [11:0] V_LAST_ACT  = 12'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [11:0] V_LAST_TOT  = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_OFF       = 12'(V_SYNC + V_BACK);

  localparam state_e H_FIRST = (H_SYNC != 0) ? ST_SYNC : ((H_BACK != 0) ? ST_BACK : ST_ACTIVE);
  localparam state_e V_FIRST = (V_SYNC != 0) ? ST_SYNC : ((V_BACK != 0) ? ST_BACK : ST_ACTIVE);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  localparam pos_t POS_RESET = '{h: 12'd0, v: 12'd0, hs: ST_SYNC, vs: ST_SYNC};
  localparam pos_t POS_START = '{h: 12'd0, v: 12'd0, hs: H_FIRST, vs: V_FIRST};

  function automatic logic [11:0] h_last(input state_e s);
    case (s)
      ST_SYNC:   return H_LAST_SYNC;
      ST_BACK:   return H_LAST_BACK;
      ST_ACTIVE: return H_LAST_ACT;
      default:   return H_LAST_TOT;
    endcase
  endfunction

  function automatic state_e h_after(input state_e s);
    case (s)
      ST_SYNC:   return (H_BACK != 0) ? ST_BACK : ST_ACTIVE;
      ST_BACK:   return ST_ACTIVE;
      ST_ACTIVE: return (H_FRONT != 0) ? ST_FRONT : H_FIRST;
      default:   return H_FIRST;
    endcase
  endfunction

  function automatic logic [11:0] v_last(input state_e s);
    case (s)
      ST_SYNC:   return V_LAST_SYNC;
      ST_BACK:   return V_LAST_BACK;
      ST_ACTIVE: return V_LAST_ACT;
      default:   return V_LAST_TOT;
    endcase
  endfunction

  function automatic state_e v_after(input state_e s);
    case (s)
      ST_SYNC:   return (V_BACK != 0) ? ST_BACK : ST_ACTIVE;
      ST_BACK:   return ST_ACTIVE;
      ST_ACTIVE: return (V_FRONT != 0) ? ST_FRONT : V_FIRST;
      default:   return V_FIRST;
    endcase
  endfunction

  // One enabled pixel step; the vertical side moves only on the horizontal wrap.
  function automatic pos_t advance(input pos_t p);
    pos_t n;
    logic h_wrap;
    n      = p;
    h_wrap = (p.h == H_LAST_TOT);
    n.h    = h_wrap ? 12'd0 : p.h + 12'd1;
    if (p.h == h_last(p.hs)) n.hs = h_after(p.hs);
    if (h_wrap) begin
      n.v = (p.v == V_LAST_TOT) ? 12'd0 : p.v + 12'd1;
      if (p.v == v_last(p.vs)) n.vs = v_after(p.vs);
    end
    return n;
  endfunction

  function automatic logic is_disp(input pos_t p);
    return (p.hs == ST_ACTIVE) && (p.vs == ST_ACTIVE);
  endfunction

  function automatic logic [XWidth-1:0] col_of(input pos_t p);
    return is_disp(p) ? XWidth'(p.h - H_OFF) : '0;
  endfunction

  function automatic logic [YWidth-1:0] row_of(input pos_t p);
    return (p.vs == ST_ACTIVE) ? YWidth'(p.v - V_OFF) : '0;
  endfunction

  pos_t              pos_q, pos_d, pos_nxt;
  logic              run_q, run_d;
  logic              hs_q, hs_d, vs_q, vs_d, disp_q, disp_d;
  logic              ls_q, ls_d, fs_q, fs_d;
  logic [XWidth-1:0] col_q, col_d;
  logic [YWidth-1:0] row_q, row_d;

  // After reset the first enabled edge lands on (0,0) rather than stepping past it.
  always_comb begin
    pos_nxt = run_q ? advance(pos_q) : POS_START;
    pos_d   = pos_q;
    run_d   = run_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    disp_d  = disp_q;
    col_d   = col_q;
    row_d   = row_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    if (iEnable) begin
      pos_d  = pos_nxt;
      run_d  = 1'b1;
      hs_d   = (pos_nxt.hs == ST_SYNC) ? HS_ON : ~HS_ON;
      vs_d   = (pos_nxt.vs == ST_SYNC) ? VS_ON : ~VS_ON;
      disp_d = is_disp(pos_nxt);
      col_d  = col_of(pos_nxt);
      row_d  = row_of(pos_nxt);
      ls_d   = (pos_nxt.h == 12'd0);
      fs_d   = (pos_nxt.h == 12'd0) && (pos_nxt.v == 12'd0);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pos_q  <= POS_RESET;
      run_q  <= 1'b0;
      hs_q   <= ~HS_ON;
      vs_q   <= ~VS_ON;
      disp_q <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      run_q  <= run_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      disp_q <= disp_d;
      col_q  <= col_d;
      row_q  <= row_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign oCol        = col_q;
  assign oRow        = row_q;
  assign oHSync      = hs_q;
  assign oVSync      = vs_q;
  assign oDisplay    = disp_q;
  assign oLineStart  = ls_q;
  assign oFrameStart = fs_q;

`ifdef VGA_TIMING_PREFETCH_EN
  pos_t              pos_pre;
  logic              pre_disp_q, pre_disp_d;
  logic [XWidth-1:0] pre_col_q, pre_col_d;
  logic [YWidth-1:0] pre_row_q, pre_row_d;

  // Lookahead is the position one enabled step beyond the one being registered.
  always_comb begin
    pos_pre    = advance(pos_nxt);
    pre_disp_d = pre_disp_q;
    pre_col_d  = pre_col_q;
    pre_row_d  = pre_row_q;
    if (iEnable) begin
      pre_disp_d = is_disp(pos_pre);
      pre_col_d  = col_of(pos_pre);
      pre_row_d  = row_of(pos_pre);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pre_disp_q <= 1'b0;
      pre_col_q  <= '0;
      pre_row_q  <= '0;
    end else begin
      pre_disp_q <= pre_disp_d;
      pre_col_q  <= pre_col_d;
      pre_row_q  <= pre_row_d;
    end
  end

  assign oPreCol     = pre_col_q;
  assign oPreRow     = pre_row_q;
  assign oPreDisplay = pre_disp_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen with small timing (H 8/2/3/2, V 4/1/2/1): table vectors plus stall/reset sequences.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       disp;
    logic [9:0] col;
    logic [9:0] row;
    logic       ls;
    logic       fs;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t exp;
  } vec_t;

  localparam outs_t RST_EXP = '{hs: 1'b1, vs: 1'b1, disp: 1'b0, col: 10'd0, row: 10'd0, ls: 1'b0, fs: 1'b0};

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic iEnable = 1'b0;

  logic [9:0] oCol, oRow, p_col, p_row;
  logic oHSync, oVSync, oDisplay, oLineStart, oFrameStart;
  logic p_hs, p_vs, p_disp, p_ls, p_fs;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [9:0] oPreCol, oPreRow, p_pre_col, p_pre_row;
  logic oPreDisplay, p_pre_disp;
`endif

  int checks = 0;
  int failures = 0;
  int k = 0;

  always #5 Clock = ~Clock;

  vga_timing_gen #(
    .XWidth(10), .YWidth(10),
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(0), .V_POL(0)
  ) u_dut (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable),
    .oCol(oCol), .oRow(oRow), .oHSync(oHSync), .oVSync(oVSync),
    .oDisplay(oDisplay), .oLineStart(oLineStart), .oFrameStart(oFrameStart)
`ifdef VGA_TIMING_PREFETCH_EN
    , .oPreCol(oPreCol), .oPreRow(oPreRow), .oPreDisplay(oPreDisplay)
`endif
  );

  vga_timing_gen #(
    .XWidth(10), .YWidth(10),
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_POL(1), .V_POL(1)
  ) u_pol (
    .Clock(Clock), .Reset(Reset), .iEnable(iEnable),
    .oCol(p_col), .oRow(p_row), .oHSync(p_hs), .oVSync(p_vs),
    .oDisplay(p_disp), .oLineStart(p_ls), .oFrameStart(p_fs)
`ifdef VGA_TIMING_PREFETCH_EN
    , .oPreCol(p_pre_col), .oPreRow(p_pre_row), .oPreDisplay(p_pre_disp)
`endif
  );

  function automatic outs_t mk(bit hs, bit vs, bit disp, int col, int row, bit ls, bit fs);
    outs_t o;
    o.hs = hs; o.vs = vs; o.disp = disp;
    o.col = 10'(col); o.row = 10'(row);
    o.ls = ls; o.fs = fs;
    return o;
  endfunction

  // Expected outputs after k enabled edges since reset release (active-low syncs).
  function automatic outs_t model(int kk, bit strobe_ok);
    int p, h, v;
    bit vact, act;
    if (kk == 0) return RST_EXP;
    p    = kk - 1;
    h    = p % 15;
    v    = (p / 15) % 8;
    vact = (v >= 3) && (v < 7);
    act  = vact && (h >= 5) && (h < 13);
    return mk(h >= 3, v >= 2, act, act ? h - 5 : 0, vact ? v - 3 : 0,
              strobe_ok && (h == 0), strobe_ok && (h == 0) && (v == 0));
  endfunction

  function automatic outs_t sample();
    return mk(oHSync, oVSync, oDisplay, int'(oCol), int'(oRow), oLineStart, oFrameStart);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic en);
    iEnable = en;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    iEnable = 1'b0;
    Reset   = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_outs", 32'(sample()), 32'(RST_EXP));
    check("reset_pol_syncs", {30'd0, p_hs, p_vs}, 32'd0);
    Reset = 1'b1;
    k     = 0;
  endtask

  task automatic check_cycle(string name, bit en);
    outs_t e;
    e = model(k, en);
    check(name, 32'(sample()), 32'(e));
    check({name, "_pol"}, {30'd0, p_hs, p_vs}, {30'd0, ~e.hs, ~e.vs});
`ifdef VGA_TIMING_PREFETCH_EN
    begin
      outs_t n;
      n = (k == 0) ? RST_EXP : model(k + 1, 1'b0);
      if (k == 0) n.hs = 1'b0;
      check({name, "_pre"}, {11'd0, oPreDisplay, oPreCol, oPreRow},
            {11'd0, (k == 0) ? 1'b0 : n.disp, (k == 0) ? 10'd0 : n.col, (k == 0) ? 10'd0 : n.row});
    end
`endif
  endtask

  vec_t vecs[17];

  initial begin
    int cyc, n_disp, n_vs, n_ls, n_fs;

    vecs[0]  = '{cyc: 1,   exp: mk(0, 0, 0, 0, 0, 1, 1)};
    vecs[1]  = '{cyc: 3,   exp: mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{cyc: 4,   exp: mk(1, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{cyc: 6,   exp: mk(1, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{cyc: 15,  exp: mk(1, 0, 0, 0, 0, 0, 0)};
    vecs[5]  = '{cyc: 16,  exp: mk(0, 0, 0, 0, 0, 1, 0)};
    vecs[6]  = '{cyc: 31,  exp: mk(0, 1, 0, 0, 0, 1, 0)};
    vecs[7]  = '{cyc: 46,  exp: mk(0, 1, 0, 0, 0, 1, 0)};
    vecs[8]  = '{cyc: 51,  exp: mk(1, 1, 1, 0, 0, 0, 0)};
    vecs[9]  = '{cyc: 58,  exp: mk(1, 1, 1, 7, 0, 0, 0)};
    vecs[10] = '{cyc: 59,  exp: mk(1, 1, 0, 0, 0, 0, 0)};
    vecs[11] = '{cyc: 64,  exp: mk(1, 1, 0, 0, 1, 0, 0)};
    vecs[12] = '{cyc: 66,  exp: mk(1, 1, 1, 0, 1, 0, 0)};
    vecs[13] = '{cyc: 103, exp: mk(1, 1, 1, 7, 3, 0, 0)};
    vecs[14] = '{cyc: 106, exp: mk(0, 1, 0, 0, 0, 1, 0)};
    vecs[15] = '{cyc: 120, exp: mk(1, 1, 0, 0, 0, 0, 0)};
    vecs[16] = '{cyc: 121, exp: mk(0, 0, 0, 0, 0, 1, 1)};

    // Hand-computed points across the first frame and into the second.
    do_reset();
    cyc = 0;
    foreach (vecs[i]) begin
      while (cyc < vecs[i].cyc) begin
        step(1'b1);
        cyc++;
        k++;
      end
      check($sformatf("vec_c%0d", vecs[i].cyc), 32'(sample()), 32'(vecs[i].exp));
    end

    // Full second frame: per-cycle model plus window counts.
    n_disp = 0; n_vs = 0; n_ls = 0; n_fs = 0;
    for (int c = 0; c < 120; c++) begin
      step(1'b1);
      k++;
      check_cycle("frame2", 1'b1);
      n_disp += int'(oDisplay);
      n_vs   += int'(!oVSync);
      n_ls   += int'(oLineStart);
      n_fs   += int'(oFrameStart);
    end
    check("frame2_disp_count", 32'(n_disp), 32'd32);
    check("frame2_vsync_count", 32'(n_vs), 32'd30);
    check("frame2_line_count", 32'(n_ls), 32'd8);
    check("frame2_frame_count", 32'(n_fs), 32'd1);

    // Enable toggling every cycle: one frame takes 240 cycles.
    do_reset();
    n_ls = 0; n_fs = 0;
    for (int c = 1; c <= 241; c++) begin
      bit en;
      en = (c % 2) == 1;
      step(en);
      if (en) k++;
      check_cycle("toggle", en);
      if (c <= 240) n_ls += int'(oLineStart);
      n_fs += int'(oFrameStart);
    end
    check("toggle_line_count", 32'(n_ls), 32'd8);
    check("toggle_frame_count", 32'(n_fs), 32'd2);

    // Reset mid-active-line, then restart gated by iEnable.
    do_reset();
    for (int c = 0; c < 56; c++) begin
      step(1'b1);
      k++;
    end
    check("mid_col5", 32'(oCol), 32'd5);
    check_cycle("mid_pos", 1'b1);
    #2;
    Reset = 1'b0;
    #1;
    check("async_reset_outs", 32'(sample()), 32'(RST_EXP));
    check("async_reset_pol", {30'd0, p_hs, p_vs}, 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    k = 0;
    for (int c = 0; c < 3; c++) begin
      step(1'b0);
      check_cycle("stalled_after_reset", 1'b0);
    end
    step(1'b1);
    k++;
    check("restart_framestart", {31'd0, oFrameStart}, 32'd1);
    check_cycle("restart_pos", 1'b1);
    for (int c = 0; c < 20; c++) begin
      step(1'b1);
      k++;
      check_cycle("restart_run", 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
